// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative RV32M multiply/divide unit (shift-add / restoring
//               shift-subtract) with divide-by-zero and overflow fast paths.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int                c_cnt_w = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(XLEN - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [XLEN-1:0]     r_m;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [XLEN-1:0]     r_result;

  logic                w_a_signed, w_b_signed, w_sa, w_sb;
  logic [XLEN-1:0]     w_abs_a, w_abs_b;
  logic                w_div_zero, w_ovf, w_fast;
  logic [XLEN:0]       w_mul_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_mul_fix;
  logic [XLEN-1:0]     w_hi, w_lo, w_final;

  assign w_a_signed = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b110);
  assign w_b_signed = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
  assign w_sa       = w_a_signed & r_a[XLEN-1];
  assign w_sb       = w_b_signed & r_b[XLEN-1];
  assign w_abs_a    = w_sa ? ({XLEN{1'b0}} - r_a) : r_a;
  assign w_abs_b    = w_sb ? ({XLEN{1'b0}} - r_b) : r_b;

  assign w_div_zero = r_op[2] && (r_b == '0);
  assign w_ovf      = r_op[2] && !r_op[0] && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (&r_b);
  assign w_fast     = w_div_zero || w_ovf;

  // Multiply step: carry of the XLEN+1 bit add becomes the new product MSB.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_m};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Divide step: the shifted partial remainder needs XLEN+1 bits.
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = w_rem_sh - {1'b0, r_m};
  assign w_div_next = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_mul_fix  = r_neg ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;
  assign w_hi       = r_acc[2*XLEN-1:XLEN];
  assign w_lo       = r_acc[XLEN-1:0];

  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:                 w_final = w_mul_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_mul_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = r_neg ? ({XLEN{1'b0}} - w_lo) : w_lo;
      default:                w_final = r_neg ? ({XLEN{1'b0}} - w_hi) : w_hi;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_busy   = (r_state != IDLE);
    o_valid  = 1'b0;
    o_result = r_result;
    case (r_state)
      IDLE: if (i_start) w_next = PREP;
      PREP: begin
        if (i_flush)     w_next = IDLE;
        else if (w_fast) w_next = FIN;
        else             w_next = CALC;
      end
      CALC: begin
        if (i_flush)              w_next = IDLE;
        else if (r_cnt == c_last) w_next = FIN;
      end
      default: begin
        w_next = IDLE;
        if (!i_flush) begin
          o_valid  = 1'b1;
          o_result = w_final;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_op <= i_op;
          r_a  <= i_a;
          r_b  <= i_b;
        end
        PREP: begin
          r_cnt <= '0;
          // Fast-path results are preloaded so FIN's normal selection applies.
          if (w_div_zero) begin
            r_neg <= 1'b0;
            r_acc <= {r_a, {XLEN{1'b1}}};
          end else if (w_ovf) begin
            r_neg <= 1'b0;
            r_acc <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
          end else if (!r_op[2]) begin
            r_neg <= w_sa ^ w_sb;
            r_m   <= w_abs_a;
            r_acc <= {{XLEN{1'b0}}, w_abs_b};
          end else begin
            r_neg <= r_op[1] ? w_sa : (w_sa ^ w_sb);
            r_m   <= w_abs_b;
            r_acc <= {{XLEN{1'b0}}, w_abs_a};
          end
        end
        CALC: begin
          r_cnt <= r_cnt + c_one;
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
        end
        default: if (!i_flush) r_result <= w_final;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench: vector table plus scoreboard of expected
//               results/cycles, and hand-built flush/reset/busy sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } sb_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  sb_t         sb[$];
  sb_t         mon_e;
  vec_t        vt[22];
  logic [31:0] last_res;

  muldiv_sequencer #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every o_valid must match the oldest expected entry in value and cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid at cycle %0d result %h expected none", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, result, mon_e.res);
        check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Returns the edge number at which the request is sampled.
  task automatic drive_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             output int s);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    s = cyc + 1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // lat is the cycle index of o_valid, cycle 1 being PREP.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input string name);
    int s;
    drive_start(o, x, y, s);
    sb.push_back('{exp, s + lat - 1, name});
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(name);
    last_res = exp;
  endtask

  initial begin
    int s;
    vt[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vt[1]  = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34};
    vt[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vt[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vt[4]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vt[5]  = '{3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
    vt[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vt[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vt[8]  = '{3'b101, 32'd100,       32'd7,         32'd14,        34};
    vt[9]  = '{3'b111, 32'd100,       32'd7,         32'd2,         34};
    vt[10] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vt[11] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vt[12] = '{3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 34};
    vt[13] = '{3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34};
    vt[14] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vt[15] = '{3'b110, 32'd5,         32'd0,         32'd5,         2};
    vt[16] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vt[17] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 2};
    vt[18] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vt[19] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vt[20] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vt[21] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {31'b0, busy},  32'd0);
    check("reset_valid",  {31'b0, valid}, 32'd0);
    check("reset_result", result,         32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));

    // Flush during CALC (cycle 10): idle at cycle 11, no result, then a fresh MUL.
    drive_start(3'b100, 32'd100, 32'd7, s);
    @(posedge clk); #1; start = 1'b0;
    wait_until(s + 9);
    flush = 1'b1;
    wait_until(s + 10);
    flush = 1'b0;
    check("flush_busy",   {31'b0, busy}, 32'd0);
    check("flush_result", result,        last_res);
    repeat (40) @(posedge clk);
    #1;
    check("flush_result_held", result, last_res);
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 34, "after_flush");

    // Flush in FIN outranks completion.
    drive_start(3'b000, 32'd5, 32'd6, s);
    @(posedge clk); #1; start = 1'b0;
    wait_until(s + 33);
    flush = 1'b1;
    #1;
    check("finflush_valid",  {31'b0, valid}, 32'd0);
    check("finflush_result", result,         last_res);
    wait_until(s + 34);
    flush = 1'b0;
    check("finflush_busy", {31'b0, busy}, 32'd0);

    // Start pulse while busy is ignored.
    drive_start(3'b000, 32'd3, 32'd5, s);
    sb.push_back('{32'd15, s + 33, "pulse"});
    @(posedge clk); #1; start = 1'b0;
    wait_until(s + 9);
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    wait_drain("pulse");
    last_res = 32'd15;
    repeat (40) @(posedge clk);
    #1;
    check("pulse_idle", {31'b0, busy}, 32'd0);

    // Start held high: second request lands in the IDLE cycle after FIN.
    drive_start(3'b001, 32'hFFFF_FFFE, 32'd3, s);
    sb.push_back('{32'hFFFF_FFFF, s + 33, "b2b_first"});
    sb.push_back('{32'hFFFF_FFFF, s + 35 + 33, "b2b_second"});
    wait_until(s + 35);
    start = 1'b0;
    wait_drain("b2b");
    last_res = 32'hFFFF_FFFF;

    // Asynchronous reset at cycle 20 of a DIV clears everything at once.
    drive_start(3'b100, 32'hFFFF_FFF9, 32'd2, s);
    @(posedge clk); #1; start = 1'b0;
    wait_until(s + 19);
    rst_n = 1'b0;
    #1;
    check("midreset_busy",   {31'b0, busy},  32'd0);
    check("midreset_valid",  {31'b0, valid}, 32'd0);
    check("midreset_result", result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("postreset_result", result, 32'd0);
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 34, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
